// File: rtl/fcl_dnet_defs.sv
// rtl/fcl_dnet_defs.sv - shared FSM encodings and width defaults for the DNET master
package fcl_dnet_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dnet_state_t;

    localparam int DNET_ADDR_WIDTH_DEF = 16;
    localparam int DNET_DATA_WIDTH_DEF = 32;
    localparam int TCOUNT_WIDTH        = 16;

endpackage

// File: rtl/fcl_rr_arbiter.sv
// rtl/fcl_rr_arbiter.sv - round-robin pick starting at ptr; ptr advances past each granted winner
module fcl_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant,
    output logic               any_req,
    output logic [IW-1:0]      pick
);

    logic [IW-1:0] ptr;
    int            idx;

    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_req && req[IW'(idx)]) begin
                any_req = 1'b1;
                pick    = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + IW'(1);
        end
    end

endmodule

// File: rtl/fcl_dnet_master.sv
// rtl/fcl_dnet_master.sv - multi-requester DNET bus master: arbitrate, strobe, wait for ack or timeout, respond
module fcl_dnet_master
    import fcl_dnet_defs::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DNET_ADDR_WIDTH = DNET_ADDR_WIDTH_DEF,
    parameter int DNET_DATA_WIDTH = DNET_DATA_WIDTH_DEF,
    parameter int TIMEOUT         = 16,
    // Reset value of timeout_count; nonzero only to reach saturation quickly in test
    parameter logic [TCOUNT_WIDTH-1:0] TIMEOUT_COUNT_INIT = '0
) (
    input  logic                               sys_clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*DNET_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DNET_DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                 req_done,
    output logic                               req_err,
    output logic [DNET_DATA_WIDTH-1:0]         req_rdata,
    output logic [DNET_ADDR_WIDTH-1:0]         dnet_addr_out,
    output logic [DNET_DATA_WIDTH-1:0]         dnet_data_out,
    output logic                               dnet_read,
    output logic                               dnet_write,
    input  logic [DNET_DATA_WIDTH-1:0]         dnet_data_in,
    input  logic                               dnet_ack,
    output logic                               busy,
    output logic [TCOUNT_WIDTH-1:0]            timeout_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    dnet_state_t          state;
    logic [IW-1:0]        pick;
    logic [IW-1:0]        win;
    logic                 any_req;
    logic                 grant;
    logic                 wr;
    logic [7:0]           wait_cnt;
    logic [NUM_REQ-1:0]   win_onehot;

    logic [DNET_ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DNET_DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*DNET_ADDR_WIDTH +: DNET_ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DNET_DATA_WIDTH +: DNET_DATA_WIDTH];
    end

    assign grant      = (state == ST_IDLE) && any_req;
    assign busy       = (state != ST_IDLE);
    assign win_onehot = NUM_REQ'(1) << win;

    fcl_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (sys_clk),
        .rst     (reset),
        .req     (req_valid),
        .grant   (grant),
        .any_req (any_req),
        .pick    (pick)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            win           <= '0;
            wr            <= 1'b0;
            wait_cnt      <= '0;
            dnet_addr_out <= '0;
            dnet_data_out <= '0;
            dnet_read     <= 1'b0;
            dnet_write    <= 1'b0;
            req_done      <= '0;
            req_err       <= 1'b0;
            req_rdata     <= '0;
            timeout_count <= TIMEOUT_COUNT_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        win           <= pick;
                        wr            <= req_write[pick];
                        dnet_addr_out <= addr_arr[pick];
                        dnet_data_out <= req_write[pick] ? wdata_arr[pick] : '0;
                        dnet_write    <= req_write[pick];
                        dnet_read     <= !req_write[pick];
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    dnet_read  <= 1'b0;
                    dnet_write <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack on the final wait cycle still wins over the timeout
                    if (dnet_ack) begin
                        req_done  <= win_onehot;
                        req_err   <= 1'b0;
                        req_rdata <= wr ? '0 : dnet_data_in;
                        state     <= ST_RESP;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        req_done  <= win_onehot;
                        req_err   <= 1'b1;
                        req_rdata <= '0;
                        if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    req_done <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcl_dnet_master.sv
// tb/tb_fcl_dnet_master.sv - directed self-checking bench for fcl_dnet_master
module tb_fcl_dnet_master;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_write;
    logic [63:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_done;
    logic         req_err;
    logic [31:0]  req_rdata;
    logic [15:0]  addr_o;
    logic [31:0]  data_o;
    logic         rd, wr;
    logic [31:0]  data_in = 32'h0;
    logic         slave_ack = 1'b0;
    logic         inj_ack;
    logic         ack;
    logic         busy;
    logic [15:0]  tcount;
    logic         slave_en;
    logic [31:0]  slave_rdata;

    logic [1:0]   r2_valid, r2_write;
    logic [31:0]  r2_addr;
    logic [63:0]  r2_wdata;
    logic [1:0]   r2_done;
    logic         r2_err;
    logic [31:0]  r2_rdata;
    logic [15:0]  r2_addr_o;
    logic [31:0]  r2_data_o;
    logic         r2_rd, r2_wr;
    logic [31:0]  r2_data_in;
    logic         r2_ack;
    logic         r2_busy;
    logic [15:0]  r2_tcount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ack = slave_ack | inj_ack;

    // Stub slave: registers the strobe and acks one cycle later, putting data on the bus for reads and writes alike
    always @(posedge clk) begin
        slave_ack <= slave_en & (rd | wr);
        data_in   <= (rd | wr) ? slave_rdata : 32'h0;
    end

    fcl_dnet_master dut (
        .sys_clk(clk), .reset(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .dnet_addr_out(addr_o), .dnet_data_out(data_o), .dnet_read(rd), .dnet_write(wr),
        .dnet_data_in(data_in), .dnet_ack(ack), .busy(busy), .timeout_count(tcount)
    );

    fcl_dnet_master #(.NUM_REQ(2), .TIMEOUT(2), .TIMEOUT_COUNT_INIT(16'hFFFE)) dut2 (
        .sys_clk(clk), .reset(rst),
        .req_valid(r2_valid), .req_write(r2_write), .req_addr(r2_addr), .req_wdata(r2_wdata),
        .req_done(r2_done), .req_err(r2_err), .req_rdata(r2_rdata),
        .dnet_addr_out(r2_addr_o), .dnet_data_out(r2_data_o), .dnet_read(r2_rd), .dnet_write(r2_wr),
        .dnet_data_in(r2_data_in), .dnet_ack(r2_ack), .busy(r2_busy), .timeout_count(r2_tcount)
    );

    task automatic run_one(input int c, input logic w, input logic [15:0] a, input logic [31:0] d,
                           output int k, output logic [3:0] done, output logic err,
                           output logic [31:0] rdata, output int nrd, output int nwr,
                           output logic [15:0] sa, output logic [31:0] sd);
        @(negedge clk);
        req_write[c]          = w;
        req_addr[c*16 +: 16]  = a;
        req_wdata[c*32 +: 32] = d;
        req_valid[c]          = 1'b1;
        k = 0; done = 4'h0; err = 1'b0; rdata = 32'h0; nrd = 0; nwr = 0; sa = 16'h0; sd = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rd) nrd++;
            if (wr) nwr++;
            if (rd | wr) begin sa = addr_o; sd = data_o; end
            if (req_done != 4'h0) begin
                k = i; done = req_done; err = req_err; rdata = req_rdata;
                break;
            end
        end
        req_valid[c] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        inj_ack = 1'b0; slave_en = 1'b1; slave_rdata = 32'h0;
        r2_valid = '0; r2_write = '0; r2_addr = '0; r2_wdata = '0; r2_data_in = '0; r2_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if ({rd, wr} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b expected 00", {rd, wr}); end
        total++; if (req_done !== 4'h0 || req_err !== 1'b0) begin bad++; $display("FAIL reset_done_err: got %h/%b expected 0/0", req_done, req_err); end
        total++; if (addr_o !== 16'h0 || data_o !== 32'h0 || req_rdata !== 32'h0) begin bad++; $display("FAIL reset_data: got %h %h %h expected zeros", addr_o, data_o, req_rdata); end
        total++; if (tcount !== 16'h0) begin bad++; $display("FAIL reset_tcount: got %h expected 0000", tcount); end
    endtask

    task automatic test_saturation;
        int nd;
        int first_k;
        nd = 0; first_k = 0;
        total++; if (r2_tcount !== 16'hFFFE) begin bad++; $display("FAIL sat_init: got %h expected fffe", r2_tcount); end
        r2_addr = 32'h7FFF_7FFF; r2_valid = 2'b01;
        for (int i = 1; i <= 60 && nd < 3; i++) begin
            @(negedge clk);
            if (r2_done != 2'b00) begin
                nd++;
                if (nd == 1) first_k = i;
                total++; if (r2_tcount !== 16'hFFFF) begin bad++; $display("FAIL sat_count%0d: got %h expected ffff", nd, r2_tcount); end
                total++; if (r2_err !== 1'b1 || r2_done !== 2'b01) begin bad++; $display("FAIL sat_err%0d: got %b/%b expected 1/01", nd, r2_err, r2_done); end
            end
        end
        r2_valid = 2'b00;
        total++; if (nd !== 3) begin bad++; $display("FAIL sat_dones: got %0d expected 3", nd); end
        total++; if (first_k !== 4) begin bad++; $display("FAIL sat_latency: got %0d expected 4", first_k); end
    endtask

    task automatic test_round_robin;
        int g, dn;
        int gt [5];
        int gi [5];
        logic [3:0] dv [5];
        g = 0; dn = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = 16'h0100 + 16'(i);
        req_write = 4'h0; slave_rdata = 32'h0BAD_0000; req_valid = 4'hF;
        for (int i = 1; i <= 60 && dn < 5; i++) begin
            @(negedge clk);
            if ((rd | wr) && g < 5) begin
                gt[g] = i; gi[g] = int'(addr_o) - 32'h100; g++;
                if (g == 5) req_valid = 4'h0;
            end
            if (req_done != 4'h0 && dn < 5) begin dv[dn] = req_done; dn++; end
        end
        req_valid = 4'h0;
        total++; if (g !== 5 || dn !== 5) begin bad++; $display("FAIL rr_count: got %0d grants %0d dones expected 5 5", g, dn); end
        for (int j = 0; j < g && j < dn; j++) begin
            total++; if (gi[j] !== (j % 4)) begin bad++; $display("FAIL rr_order%0d: got %0d expected %0d", j, gi[j], j % 4); end
            total++; if (dv[j] !== (4'b0001 << (j % 4))) begin bad++; $display("FAIL rr_done%0d: got %b expected %b", j, dv[j], 4'b0001 << (j % 4)); end
            if (j > 0) begin
                total++; if (gt[j] - gt[j-1] !== 4) begin bad++; $display("FAIL rr_spacing%0d: got %0d expected 4", j, gt[j] - gt[j-1]); end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_write;
        int k, nrd, nwr;
        logic [3:0] done;
        logic err;
        logic [31:0] rdata, sd;
        logic [15:0] sa;
        slave_rdata = 32'hA5A5_A5A5;
        run_one(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, k, done, err, rdata, nrd, nwr, sa, sd);
        total++; if (nwr !== 1 || nrd !== 0) begin bad++; $display("FAIL wr_strobes: got wr=%0d rd=%0d expected 1 0", nwr, nrd); end
        total++; if (sa !== 16'h0010 || sd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_bus: got %h %h expected 0010 deadbeef", sa, sd); end
        total++; if (done !== 4'b0001 || err !== 1'b0) begin bad++; $display("FAIL wr_done: got %b/%b expected 0001/0", done, err); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata: got %h expected 0", rdata); end
        total++; if (k !== 3) begin bad++; $display("FAIL wr_latency: got %0d expected 3", k); end
        @(negedge clk);
        total++; if (req_done !== 4'h0) begin bad++; $display("FAIL wr_done_pulse: got %b expected 0000", req_done); end
        repeat (2) @(negedge clk);
        total++; if (addr_o !== 16'h0010 || data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL idle_hold: got %h %h expected 0010 deadbeef", addr_o, data_o); end
    endtask

    task automatic test_single_read;
        int k, nrd, nwr;
        logic [3:0] done;
        logic err;
        logic [31:0] rdata, sd;
        logic [15:0] sa;
        slave_rdata = 32'h1234_5678;
        run_one(2, 1'b0, 16'h0004, 32'hFFFF_FFFF, k, done, err, rdata, nrd, nwr, sa, sd);
        total++; if (nrd !== 1 || nwr !== 0) begin bad++; $display("FAIL rd_strobes: got rd=%0d wr=%0d expected 1 0", nrd, nwr); end
        total++; if (sa !== 16'h0004 || sd !== 32'h0) begin bad++; $display("FAIL rd_bus: got %h %h expected 0004 00000000", sa, sd); end
        total++; if (done !== 4'b0100 || err !== 1'b0) begin bad++; $display("FAIL rd_done: got %b/%b expected 0100/0", done, err); end
        total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata: got %h expected 12345678", rdata); end
        total++; if (k !== 3) begin bad++; $display("FAIL rd_latency: got %0d expected 3", k); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int k, nrd, nwr, late;
        logic [3:0] done;
        logic err;
        logic [31:0] rdata, sd;
        logic [15:0] sa;
        late = 0;
        slave_en = 1'b0; slave_rdata = 32'hFFFF_0000;
        run_one(1, 1'b0, 16'h7FFF, 32'h0, k, done, err, rdata, nrd, nwr, sa, sd);
        total++; if (k !== 18) begin bad++; $display("FAIL to_latency: got %0d expected 18", k); end
        total++; if (done !== 4'b0010 || err !== 1'b1) begin bad++; $display("FAIL to_done: got %b/%b expected 0010/1", done, err); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h expected 0", rdata); end
        total++; if (tcount !== 16'h1) begin bad++; $display("FAIL to_count: got %h expected 0001", tcount); end
        @(negedge clk);
        inj_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (req_done != 4'h0) late++;
        end
        inj_ack = 1'b0;
        total++; if (late !== 0) begin bad++; $display("FAIL late_ack_done: got %0d pulses expected 0", late); end
        total++; if (tcount !== 16'h1 || busy !== 1'b0) begin bad++; $display("FAIL late_ack_state: got %h/%b expected 0001/0", tcount, busy); end
        slave_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int spur;
        logic seen;
        spur = 0; seen = 1'b0;
        slave_rdata = 32'h5555_AAAA;
        @(negedge clk);
        req_write = 4'h0; req_addr[16 +: 16] = 16'h0222; req_valid = 4'b0010;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        total++; if ({rd, wr} !== 2'b00 || req_done !== 4'h0) begin bad++; $display("FAIL rstmid_outputs: got %b/%b expected 00/0000", {rd, wr}, req_done); end
        req_valid = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (req_done != 4'h0) spur++;
        end
        total++; if (spur !== 0) begin bad++; $display("FAIL rstmid_nodone: got %0d pulses expected 0", spur); end
        for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = 16'h0300 + 16'(i);
        req_valid = 4'hF;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (rd | wr) begin
                seen = 1'b1;
                total++; if (addr_o !== 16'h0300) begin bad++; $display("FAIL rstmid_first_grant: got %h expected 0300", addr_o); end
            end
        end
        req_valid = 4'h0;
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_grant_seen: got %b expected 1", seen); end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_saturation;
        test_round_robin;
        test_single_write;
        test_single_read;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
